// File: rtl/serial_adder.sv
// Bit-serial ripple adder: adds two WIDTH-bit operands plus carry-in one bit
// per clock, LSB first, through a single full adder and a three-state FSM.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [1:0]       dbg_state
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic             carry_q;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_c;

    assign fa_s      = a_q[0] ^ b_q[0] ^ carry_q;
    assign fa_c      = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
    assign dbg_state = state;

    // Handshake: start is accepted only on an edge where the FSM is IDLE; busy
    // stays high from the accepting edge until DONE retires, and done pulses for
    // one cycle with sum/cout already valid. sum/cout then hold until the next done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    res_q   <= {fa_s, res_q[WIDTH-1:1]};
                    carry_q <= fa_c;
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    if (cnt == LAST) begin
                        // Final bit: publish the result directly so it is valid with done.
                        sum   <= {fa_s, res_q[WIDTH-1:1]};
                        cout  <= fa_c;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder (WIDTH=8): directed corner cases plus a random sweep,
// scored against plain integer addition through an expected-result queue.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic [1:0]   dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int cyc      = 0;

    logic [W:0] exp_q[$];
    int         done_cyc[$];

    serial_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int unsigned t;
        t = int'(x) + int'(y) + (c ? 1 : 0);
        return t[W:0];
    endfunction

    // monitor: every done pulse is scored against the oldest expectation
    always @(negedge clk) begin
        if (rst_n && done) begin
            done_cnt++;
            done_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'(0));
            end else begin
                logic [W:0] e;
                e = exp_q.pop_front();
                chk("result", 32'({cout, sum}), 32'(e));
            end
        end
    end

    // driver: present operands, accept on the next edge, record expectation
    task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        @(negedge clk);
        a = x; b = y; cin = c; start = 1'b1;
        @(posedge clk);
        exp_q.push_back(model(x, y, c));
        #1 start = 1'b0;
    endtask

    // edges counts from and including the accepting edge
    task automatic wait_done(output int edges, output int bcnt);
        edges = 1;
        bcnt  = busy ? 1 : 0;
        while (!done && edges < 40) begin
            @(posedge clk); #1;
            edges++;
            if (busy) bcnt++;
        end
        if (!done) chk("done_timeout", 32'(0), 32'(1));
        @(posedge clk); #1;
        chk("idle_after_done_busy", 32'(busy), 32'(0));
        chk("idle_after_done_done", 32'(done), 32'(0));
    endtask

    initial begin
        int lat, bc, d0;
        logic [W-1:0] x, y;
        logic c;

        // reset state
        #12;
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_sum", 32'(sum), 32'(0));
        chk("rst_cout", 32'(cout), 32'(0));
        @(negedge clk); rst_n = 1'b1;

        // basic add: latency and busy width
        start_op(8'h0F, 8'h01, 1'b0);
        wait_done(lat, bc);
        chk("latency_edges", 32'(lat), 32'(W + 1));
        chk("busy_cycles", 32'(bc), 32'(W + 1));

        // carry ripples across every bit
        start_op(8'hFF, 8'h01, 1'b0);
        wait_done(lat, bc);

        // all ones with carry-in, then zeros; result held while shifting
        start_op(8'hFF, 8'hFF, 1'b1);
        wait_done(lat, bc);
        start_op(8'h00, 8'h00, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("hold_sum", 32'(sum), 32'hFF);
        chk("hold_cout", 32'(cout), 32'(1));
        wait_done(lat, bc);

        // second start while busy, with new operands, is ignored
        d0 = done_cnt;
        start_op(8'h12, 8'h34, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        a = 8'h55; b = 8'h66; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(lat, bc);
        repeat (3) @(posedge clk);
        #1;
        chk("single_done", 32'(done_cnt - d0), 32'(1));

        // asynchronous reset mid-operation
        start_op(8'hAB, 8'hCD, 1'b1);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete();
        d0 = done_cnt;
        chk("midrst_busy", 32'(busy), 32'(0));
        chk("midrst_sum", 32'(sum), 32'(0));
        chk("midrst_cout", 32'(cout), 32'(0));
        chk("midrst_done", 32'(done), 32'(0));
        repeat (12) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        start_op(8'h3C, 8'h0A, 1'b1);
        wait_done(lat, bc);
        chk("post_rst_latency", 32'(lat), 32'(W + 1));
        chk("no_done_during_rst", 32'(done_cnt - d0), 32'(1));

        // start held high: accepted every W+2 cycles, operands vary every cycle
        done_cyc.delete();
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom); start = 1'b1;
            @(posedge clk);
            if (k % (W + 2) == 0) exp_q.push_back(model(a, b, cin));
        end
        @(negedge clk); start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("held_done_count", 32'(done_cyc.size()), 32'(3));
        if (done_cyc.size() == 3) begin
            chk("held_spacing_0", 32'(done_cyc[1] - done_cyc[0]), 32'(W + 2));
            chk("held_spacing_1", 32'(done_cyc[2] - done_cyc[1]), 32'(W + 2));
        end

        // random sweep
        for (int i = 0; i < 500; i++) begin
            x = W'($urandom);
            y = W'($urandom_range(0, (1 << W) - 1));
            c = 1'($urandom);
            start_op(x, y, c);
            wait_done(lat, bc);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand and sum width in bits; legal range 2..32.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: start  input  1  request to begin an addition; sampled only in IDLE.
REQ-006 Port: a  input  WIDTH  operand A; captured on the accepted start edge.
REQ-007 Port: b  input  WIDTH  operand B; captured on the accepted start edge.
REQ-008 Port: cin  input  1  carry-in; captured on the accepted start edge.
REQ-009 Port: busy  output  1  high while in SHIFT or DONE.
REQ-010 Port: done  output  1  one-cycle pulse; result valid.
REQ-011 Port: sum  output  WIDTH  registered result.
REQ-012 Port: cout  output  1  registered carry-out.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-014 In IDLE with start=1 at a clock edge, the block SHALL do all of the following on that edge:
- load the A and B shift registers;
- set carry_q to cin;
- clear the bit counter;
- enter SHIFT.
REQ-015 In IDLE with start=0, the block SHALL hold all state.
REQ-016 In SHIFT, on each edge the block SHALL do all of the following:
- compute the LSB full-adder sum s = a0^b0^carry_q and carry c = a0&b0 | a0&carry_q | b0&carry_q;
- shift s into the MSB of the result register, which shifts right;
- load c into carry_q;
- shift A and B right by one;
- increment the counter.
REQ-017 The block SHALL process bits LSB first, exactly WIDTH bits per operation.
REQ-018 SHIFT SHALL go to DONE on the edge where the counter equals WIDTH-1; that edge processes the final bit.
REQ-019 On entry to DONE, the block SHALL present the result register on sum and the final carry_q on cout.
REQ-020 In DONE, done SHALL be 1 for exactly one cycle, and the next edge SHALL return the FSM to IDLE unconditionally.
REQ-021 Latency SHALL be fixed: done is high in the cycle following the (WIDTH+1)th rising edge after, and including, the accepted start edge.
REQ-022 The block SHALL ignore start while busy=1; operands, carry and counter SHALL be unaffected.
REQ-023 sum and cout SHALL hold their last value from DONE until the next DONE; intermediate shifting SHALL NOT disturb them.
REQ-024 Changes on a, b or cin after the accepted start edge SHALL have no effect on the current operation.
REQ-025 The counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL NOT wrap within an operation.
REQ-026 The minimum spacing between accepted starts SHALL be WIDTH+2 cycles; start held high continuously SHALL yield back-to-back operations at that rate.
REQ-027 done and busy SHALL be driven from registered state only, with no combinational path from any input.

Reset
REQ-028 While rst_n=0, the block SHALL hold the FSM in IDLE and zero the following registers: busy, done, sum, cout, carry_q, counter, A, B and result.
REQ-029 Assertion of rst_n SHALL take effect immediately, independent of clk.
REQ-030 Reset mid-operation SHALL abandon the operation with no done pulse, and sum/cout SHALL read 0.
REQ-031 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted.

Verification
REQ-032 The bench SHALL cover these scenarios, with WIDTH=8:
- a=8'h0F, b=8'h01, cin=0 -> sum=8'h10, cout=0; done exactly 9 edges after the start edge; busy high for 9 cycles.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1; carry ripples through all 8 bits.
- a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1; then a=8'h00, b=8'h00, cin=0 -> sum=8'h00, cout=0, with sum/cout held in between.
- start pulsed again at cycle 3 of an operation with different operands -> ignored; the original result appears, and only one done pulse occurs.
- rst_n low at cycle 4 of an operation -> busy=0, sum=0, cout=0 immediately, no done pulse; a new start after release completes correctly.
- start held high for 30 cycles -> done pulses every 10 cycles; a 500-vector random sweep matches {cout,sum} = a+b+cin.
